// File: rtl/npc_lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Funct3 encodings, the "no access" code and the access-sequencing state enum.
package npc_lsu_pkg;

  localparam logic [2:0] LSU_NONE = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  // Halfword accesses need addr[0]==0; word accesses need addr[1:0]==0.
  function automatic logic lsu_misaligned(logic [2:0] f3, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) begin
      mis = off[0];
    end else if (f3 == F3_W) begin
      mis = |off;
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed lane of a read word and extends it per the load funct3.
// Purely combinational.
module lsu_load_align
  import npc_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  always_comb begin
    lane   = rdata_i >> {addr_lo_i, 3'b000};
    data_o = lane;
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data_o = {24'h000000, lane[7:0]};
      F3_HU:   data_o = {16'h0000, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between the decoder and a req/gnt/rvalid
// data memory; stalls the core until the access completes or times out.
module lsu
  import npc_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic [2:0]  is_load,
  input  logic [2:0]  is_store,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [TO_W:0] ToLimit = (TO_W + 1)'(TIMEOUT_CYCLES);

  lsu_state_e state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     ldata_q, ldata_d;

  logic            ld_v, st_v, access, legal, mis;
  logic [2:0]      f3;
  logic [31:0]     fmt_wdata;
  logic [3:0]      fmt_wstrb;
  logic [TO_W:0]   cnt_inc;
  logic [TO_W-1:0] cnt_sat;
  logic            timeout;
  logic [31:0]     aligned;

  lsu_load_align u_load_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (off_q),
    .funct3_i  (op_q),
    .data_o    (aligned)
  );

  // Request decode and store formatting in the issuing cycle.
  always_comb begin
    ld_v   = (is_load != LSU_NONE);
    st_v   = (is_store != LSU_NONE);
    access = issue & (ld_v | st_v);
    f3     = ld_v ? is_load : is_store;
    legal  = 1'b0;
    if (ld_v && !st_v) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    end else if (st_v && !ld_v) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    mis       = lsu_misaligned(f3, addr[1:0]);
    fmt_wdata = 32'h0;
    fmt_wstrb = 4'b0000;
    if (st_v) begin
      case (f3)
        F3_B: begin
          fmt_wdata = {4{store_data[7:0]}};
          fmt_wstrb = 4'b0001 << addr[1:0];
        end
        F3_H: begin
          fmt_wdata = {2{store_data[15:0]}};
          fmt_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          fmt_wdata = store_data;
          fmt_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Counter saturates so a gnt on the expiry cycle cannot wrap it back below the limit.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (TO_W + 1)'(1);
    cnt_sat = cnt_inc[TO_W] ? cnt_q : cnt_inc[TO_W-1:0];
    timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc >= ToLimit);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ldata_d = ldata_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (!legal || mis) begin
            err_d   = 1'b1;
            ldata_d = 32'h0;
            state_d = RESP;
          end else begin
            op_d    = f3;
            off_d   = addr[1:0];
            we_d    = st_v;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = fmt_wdata;
            wstrb_d = fmt_wstrb;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_sat;
        if (mem_gnt) begin
          if (we_q) begin
            ldata_d = 32'h0;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          ldata_d = 32'h0;
          state_d = RESP;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_sat;
        if (mem_rvalid) begin
          ldata_d = aligned;
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          ldata_d = 32'h0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ldata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ldata_q <= ldata_d;
    end
  end

  // Memory payload is only driven while a request is outstanding.
  always_comb begin
    done      = (state_q == RESP);
    err       = done & err_q;
    load_data = done ? ldata_q : 32'h0;
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? addr_q : 32'h0;
    mem_wdata = mem_req ? wdata_q : 32'h0;
    mem_wstrb = mem_req ? wstrb_q : 4'b0000;
  end

endmodule
